instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_pkg.sv | 50 +++++
 rtl/instruction_loader_if.sv | 37 +++
 rtl/instruction_loader_word_assembler.sv | 56 +++++
 rtl/instruction_loader.sv | 121 ++++++++++++
 tb/tb_instruction_loader.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding,
// program-slot geometry and the fixed base address of every slot.
package instruction_loader_pkg;

  // Words in one program slot and the matching memory geometry.
  localparam int SLOT_WORDS       = 512;
  localparam int MEM_ADDR_WIDTH   = 11;
  localparam int WORD_COUNT_WIDTH = 10;
  localparam int SLOT_SEL_WIDTH   = 2;
  localparam int BYTE_WIDTH       = 8;

  // Base word address of each slot: slot 0 holds the operating system,
  // slots 1-3 hold user programs.
  localparam logic [MEM_ADDR_WIDTH-1:0] SLOT_BASE_OS = 11'd0;
  localparam logic [MEM_ADDR_WIDTH-1:0] SLOT_BASE_P1 = 11'd512;
  localparam logic [MEM_ADDR_WIDTH-1:0] SLOT_BASE_P2 = 11'd1024;
  localparam logic [MEM_ADDR_WIDTH-1:0] SLOT_BASE_P3 = 11'd1536;

  // Loader control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Map a slot selector onto the first word address of that slot.
  function automatic logic [MEM_ADDR_WIDTH-1:0] slot_base(
    input logic [SLOT_SEL_WIDTH-1:0] sel
  );
    logic [MEM_ADDR_WIDTH-1:0] base;
    case (sel)
      2'd0:    base = SLOT_BASE_OS;
      2'd1:    base = SLOT_BASE_P1;
      2'd2:    base = SLOT_BASE_P2;
      default: base = SLOT_BASE_P3;
    endcase
    return base;
  endfunction

  // Requested word counts larger than a slot are limited to the slot size.
  function automatic logic [WORD_COUNT_WIDTH-1:0] clip_count(
    input logic [WORD_COUNT_WIDTH-1:0] requested
  );
    logic [WORD_COUNT_WIDTH-1:0] limit;
    limit = WORD_COUNT_WIDTH'(SLOT_WORDS);
    return (requested > limit) ? limit : requested;
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input, load control and instruction-memory write port of
// the instruction loader, bundled so the whole port list travels as one.
interface instruction_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  // load request
  logic                  start;
  logic [1:0]            slot;
  logic [9:0]            word_count;
  // byte stream
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  // instruction memory write port
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_write_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  // status
  logic                  busy;
  logic                  done;
  logic                  error;

  // Side that issues loads, supplies bytes and owns the memory.
  modport master (
    output start, slot, word_count, byte_valid, byte_data,
    input  byte_ready, mem_write_enable, mem_write_address, mem_write_data,
    input  busy, done, error
  );

  // The loader itself.
  modport slave (
    input  start, slot, word_count, byte_valid, byte_data,
    output byte_ready, mem_write_enable, mem_write_address, mem_write_data,
    output busy, done, error
  );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Packs a stream of bytes into one instruction word, most-significant byte
// first, and reports when the byte about to be shifted in is the last one.
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic [BYTE_WIDTH-1:0] byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  last_byte_o
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_WIDTH      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_WIDTH-1:0]  byte_idx_q, byte_idx_d;

  // Next word/index: a clear wins over a shift so a new load starts clean.
  always_comb begin
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    if (clear_i) begin
      word_d     = '0;
      byte_idx_d = '0;
    end else if (shift_i) begin
      // Earlier bytes move up; the newest byte lands in the low byte.
      word_d = {word_q[DATA_WIDTH-BYTE_WIDTH-1:0], byte_i};
      if (byte_idx_q == IDX_WIDTH'(BYTES_PER_WORD - 1)) begin
        byte_idx_d = '0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
  end

  // Assembly register and byte counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign word_o      = word_q;
  // Independent of shift_i so the controller can combine it without a loop.
  assign last_byte_o = (byte_idx_q == IDX_WIDTH'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte stream into one slot of instruction memory: bytes are packed
// into words, each complete word is written one cycle later at
// slot base + word index, and done pulses once the requested count is in.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int SLOT_WORDS = 512
) (
  input  logic                 clock,
  input  logic                 reset,
  instruction_loader_if.slave  bus
);

  state_t                        state_q, state_d;
  logic [SLOT_SEL_WIDTH-1:0]     slot_q, slot_d;
  logic [WORD_COUNT_WIDTH-1:0]   count_q, count_d;
  logic [WORD_COUNT_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic                          error_q, error_d;

  logic                          asm_clear;
  logic                          asm_shift;
  logic                          asm_last_byte;
  logic [DATA_WIDTH-1:0]         asm_word;
  logic [WORD_COUNT_WIDTH-1:0]   word_idx_inc;
  logic                          write_active;

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (asm_clear),
    .shift_i     (asm_shift),
    .byte_i      (bus.byte_data),
    .word_o      (asm_word),
    .last_byte_o (asm_last_byte)
  );

  assign word_idx_inc = word_idx_q + 1'b1;

  // Next-state logic: load acceptance, byte intake and word sequencing.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    error_d    = error_q;
    asm_clear  = 1'b0;
    asm_shift  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          slot_d     = bus.slot;
          count_d    = clip_count(bus.word_count);
          error_d    = (bus.word_count > WORD_COUNT_WIDTH'(SLOT_WORDS));
          word_idx_d = '0;
          asm_clear  = 1'b1;
          state_d    = (bus.word_count == '0) ? ST_DONE : ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        // byte_ready is high throughout this state, so valid alone accepts.
        if (bus.byte_valid) begin
          asm_shift = 1'b1;
          if (asm_last_byte) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_inc;
        state_d    = (word_idx_inc == count_q) ? ST_DONE : ST_RECEIVE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      error_q    <= error_d;
    end
  end

  // A reset arriving while in WRITE suppresses that cycle's strobe too.
  assign write_active = (state_q == ST_WRITE) && !reset;

  // Status and memory-port outputs, decoded from the current state.
  always_comb begin
    bus.byte_ready        = (state_q == ST_RECEIVE);
    bus.busy              = (state_q != ST_IDLE);
    bus.done              = (state_q == ST_DONE);
    bus.error             = error_q;
    bus.mem_write_enable  = write_active;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
    if (write_active) begin
      // count_q never exceeds SLOT_WORDS, so the index stays inside the slot.
      bus.mem_write_address = ADDR_WIDTH'(slot_base(slot_q)) + ADDR_WIDTH'(word_idx_q);
      bus.mem_write_data    = asm_word;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized scoreboard bench for instruction_loader: the stimulus side
// predicts every memory write and done pulse from the byte stream it sends,
// and an independent monitor checks whatever the DUT actually presents.
module tb_instruction_loader;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic err;
    logic had_writes;
  } dn_t;

  logic clock;
  logic reset;

  instruction_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus ();

  instruction_loader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (11),
    .SLOT_WORDS (512)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int  vectors;
  int  miscompares;
  wr_t wr_q[$];
  dn_t dn_q[$];
  logic [7:0] stream_q[$];

  // ---------------------------------------------------------------- monitor
  initial begin
    wr_t  exp_w;
    dn_t  exp_d;
    bit   prev_done;
    int   cyc;
    int   last_wr_cyc;
    prev_done   = 1'b0;
    cyc         = 0;
    last_wr_cyc = -10;
    forever begin
      @(negedge clock);
      cyc++;
      if (bus.mem_write_enable) begin
        vectors++;
        if (bus.byte_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL ready_in_write: byte_ready=%b required 0", bus.byte_ready);
        end
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr=%0d data=%h, none required",
                   bus.mem_write_address, bus.mem_write_data);
        end else begin
          exp_w = wr_q.pop_front();
          if (bus.mem_write_address !== exp_w.addr || bus.mem_write_data !== exp_w.data) begin
            miscompares++;
            $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                     bus.mem_write_address, bus.mem_write_data, exp_w.addr, exp_w.data);
          end else begin
            $display("write addr=%0d data=%h", bus.mem_write_address, bus.mem_write_data);
          end
        end
        last_wr_cyc = cyc;
      end else if (bus.mem_write_address !== 11'd0 || bus.mem_write_data !== 32'd0) begin
        vectors++;
        miscompares++;
        $display("FAIL idle_bus: addr=%0d data=%h while not writing, required 0",
                 bus.mem_write_address, bus.mem_write_data);
      end
      if (bus.done) begin
        vectors++;
        if (prev_done) begin
          miscompares++;
          $display("FAIL done_width: done high on consecutive cycles, required one-cycle pulse");
        end else if (dn_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: done=1, no load outstanding");
        end else begin
          exp_d = dn_q.pop_front();
          if (bus.error !== exp_d.err || wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL done: error=%b pending_writes=%0d, required error=%b pending_writes=0",
                     bus.error, wr_q.size(), exp_d.err);
          end else if (exp_d.had_writes && cyc != last_wr_cyc + 1) begin
            miscompares++;
            $display("FAIL done_latency: done %0d cycles after last write, required 1",
                     cyc - last_wr_cyc);
          end else begin
            $display("done error=%b", bus.error);
          end
        end
      end
      prev_done = bus.done;
    end
  end

  // ------------------------------------------------------------- utilities
  task automatic check_reset_outputs(input string name);
    logic [6:0] got;
    @(negedge clock);
    got = {bus.byte_ready, bus.mem_write_enable, |bus.mem_write_address,
           |bus.mem_write_data, bus.busy, bus.done, bus.error};
    vectors++;
    if (got !== 7'b0) begin
      miscompares++;
      $display("FAIL %s: {ready,we,addr!=0,data!=0,busy,done,error}=%b required 0000000", name, got);
    end else begin
      $display("%s: outputs at reset values", name);
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clock); #1;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic recover(input string why);
    miscompares++;
    $display("FAIL %s: bound expired, required the load to finish", why);
    apply_reset(2);
    reset = 1'b0;
    wr_q.delete();
    dn_q.delete();
  endtask

  // One complete load. mode: 0 back-to-back, 1 valid every other cycle,
  // 2 random valid. inject_at >= 0 pulses a stray start at that byte;
  // abort_after >= 0 asserts reset once that many bytes have been accepted.
  task automatic run_load(input logic [1:0] s, input logic [9:0] cnt, input int mode,
                          input int inject_at, input int abort_after);
    int   eff;
    int   nbytes;
    int   bi;
    int   cyc;
    int   stall;
    int   waited;
    bit   acc;
    bit   injected;
    bit   v;
    wr_t  w;
    dn_t  d;

    eff = (cnt > 10'd512) ? 512 : int'(cnt);
    if (stream_q.size() == 0) begin
      for (int i = 0; i < eff * 4; i++) stream_q.push_back(8'($urandom));
    end
    nbytes = (abort_after >= 0) ? abort_after : eff * 4;

    // Reference: word w of the stream lands at slot*512 + w, big-endian.
    for (int k = 0; k < eff; k++) begin
      if ((k + 1) * 4 <= nbytes) begin
        w.addr = 11'(int'(s) * 512 + k);
        w.data = {stream_q[4*k], stream_q[4*k+1], stream_q[4*k+2], stream_q[4*k+3]};
        wr_q.push_back(w);
      end
    end
    if (abort_after < 0) begin
      d.err = (cnt > 10'd512);
      d.had_writes = (eff > 0);
      dn_q.push_back(d);
    end
    $display("load slot=%0d count=%0d mode=%0d inject=%0d abort=%0d",
             s, cnt, mode, inject_at, abort_after);

    @(posedge clock); #1;
    bus.start      = 1'b1;
    bus.slot       = s;
    bus.word_count = cnt;
    @(posedge clock); #1;
    bus.start      = 1'b0;
    bus.slot       = 2'($urandom);
    bus.word_count = 10'($urandom);

    if (cnt == 10'd0) begin
      @(negedge clock);
      vectors++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_count_first: busy=%b done=%b required busy=1 done=1", bus.busy, bus.done);
      end
      @(negedge clock);
      vectors++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_count_second: busy=%b done=%b required busy=0 done=0", bus.busy, bus.done);
      end
      stream_q.delete();
      return;
    end

    bi = 0; cyc = 0; stall = 0; injected = 1'b0;
    while (bi < nbytes) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.byte_valid = v;
      bus.byte_data  = v ? stream_q[bi] : 8'($urandom);
      if (inject_at >= 0 && bi == inject_at && !injected) begin
        bus.start      = 1'b1;
        bus.slot       = 2'($urandom);
        bus.word_count = 10'($urandom);
        injected       = 1'b1;
      end
      @(negedge clock);
      acc = bus.byte_valid && bus.byte_ready;
      @(posedge clock); #1;
      bus.start = 1'b0;
      if (acc) begin
        bi++;
        stall = 0;
      end else begin
        stall++;
      end
      cyc++;
      if (stall > 50) break;
    end
    bus.byte_valid = 1'b0;
    stream_q.delete();

    if (stall > 50) begin
      recover("byte_accept_timeout");
      return;
    end

    if (abort_after >= 0) begin
      reset = 1'b1;
      @(posedge clock); #1;
      check_reset_outputs("abort_reset");
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (6) @(posedge clock);
      vectors++;
      if (wr_q.size() != 0) begin
        miscompares++;
        $display("FAIL abort_writes: %0d writes outstanding, required 0", wr_q.size());
        wr_q.delete();
      end
      return;
    end

    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (bus.busy && waited < 20);
    if (bus.busy) recover("done_timeout");
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.slot       = 2'd0;
    bus.word_count = 10'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("power_on_reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Single known word into the OS slot.
    stream_q = '{8'h20, 8'h08, 8'h00, 8'h05};
    run_load(2'd0, 10'd1, 0, -1, -1);

    // Three words with a stalling source.
    run_load(2'd2, 10'd3, 1, -1, -1);

    // Oversized request: clipped to a full slot, error raised and held.
    run_load(2'd3, 10'd600, 0, -1, -1);
    @(negedge clock);
    vectors++;
    if (bus.error !== 1'b1) begin
      miscompares++;
      $display("FAIL error_sticky: error=%b required 1", bus.error);
    end

    // Empty load (also clears error, checked at its done pulse).
    run_load(2'($urandom), 10'd0, 0, -1, -1);

    // Reset two bytes into the second word, then a clean reload.
    run_load(2'd1, 10'd3, 0, -1, 6);
    run_load(2'd1, 10'd2, 2, -1, -1);

    // Stray start while busy.
    run_load(2'd2, 10'd4, 2, 5, -1);
    run_load(2'd0, 10'd2, 0, 7, -1);

    // Randomized loads.
    for (int n = 0; n < 10; n++) begin
      run_load(2'($urandom), 10'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1, -1);
    end

    repeat (4) @(posedge clock);
    vectors++;
    if (wr_q.size() != 0 || dn_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftovers: writes=%0d dones=%0d outstanding, required 0", wr_q.size(), dn_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
